bcd_counter_display: RTL and testbench

Parametrised successor to the free-running counter, 1 s timer and 2-digit seg path. It is an N-digit BCD up/down counter with a built-in tick prescaler, synchronous clear and load, and wrap or saturate mode. It drives one registered, active-low 7-segment pattern per digit. The block sits between the board clock and the seg outputs and replaces the separate timer, counter and %10 / /10 logic at top level.

---
 rtl/bcd_seg_pkg.sv | 36 +++
 rtl/bcd_digit_cell.sv | 47 ++++
 rtl/bcd_counter_display.sv | 131 +++++++++++++
 tb/tb_bcd_counter_display.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_seg_pkg.sv
// rtl/bcd_seg_pkg.sv - segment codes and BCD-to-7-segment encoder
package bcd_seg_pkg;

    // Active-low patterns, bit0=a .. bit6=g, bit7=dp (kept off)
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Non-decimal nibbles show as blank rather than garbage
    function automatic logic [7:0] seg_encode(input logic [3:0] digit);
        logic [7:0] code;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - one BCD digit with carry/borrow ripple
module bcd_digit_cell (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       step,
    input  logic       up,
    input  logic       cin,
    output logic [3:0] digit,
    output logic       cout,
    output logic       is_max,
    output logic       is_zero
);

    logic [3:0] r_digit;
    logic [3:0] w_load_clamped;

    // Out-of-range load nibbles saturate to 9 so the digit always stays decimal
    assign w_load_clamped = (load_val > 4'd9) ? 4'd9 : load_val;

    assign is_max  = (r_digit == 4'd9);
    assign is_zero = (r_digit == 4'd0);
    assign digit   = r_digit;

    // Carry (up) or borrow (down) propagates only when this digit rolls over
    assign cout = cin & (up ? is_max : is_zero);

    // Digit register: clear beats load beats step; steps only when the lower digits roll
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_digit <= 4'd0;
        end else if (clear) begin
            r_digit <= 4'd0;
        end else if (load) begin
            r_digit <= w_load_clamped;
        end else if (step && cin) begin
            if (up) begin
                r_digit <= is_max ? 4'd0 : r_digit + 4'd1;
            end else begin
                r_digit <= is_zero ? 4'd9 : r_digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_counter_display.sv
// rtl/bcd_counter_display.sv - N-digit BCD up/down counter with prescaler and 7-seg outputs
module bcd_counter_display
    import bcd_seg_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 50_000_000,
    parameter int PW       = $clog2(TICK_DIV)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  wrap_mode,
    input  logic                  lz_blank,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  tick,
    output logic                  wrap,
    output logic                  at_limit,
    output logic [8*DIGITS-1:0]   seg
);

    localparam logic [PW-1:0] LP_PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]         r_presc;
    logic                  r_tick;
    logic                  r_wrap;
    logic [8*DIGITS-1:0]   r_seg;

    logic [4*DIGITS-1:0]   w_count;
    logic [DIGITS-1:0]     w_cin;
    logic [DIGITS-1:0]     w_cout;
    logic [DIGITS-1:0]     w_max;
    logic [DIGITS-1:0]     w_zero;
    logic                  w_step;
    logic                  w_hz;
    logic [8*DIGITS-1:0]   w_seg_next;

    // Limit is judged against the direction currently requested
    assign at_limit = up ? (&w_max) : (&w_zero);

    // A tick advances the count unless clear/load win, or saturate mode pins it at the limit
    assign w_step = r_tick & ~clear & ~load & (~at_limit | wrap_mode);

    // Prescaler: free-runs while enabled, clear restarts a full period
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else if (clear) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else if (en) begin
            if (r_presc == LP_PRESC_LAST) begin
                r_presc <= '0;
                r_tick  <= 1'b1;
            end else begin
                r_presc <= r_presc + PW'(1);
                r_tick  <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    // Ripple chain: digit 0 always sees a carry-in when stepping
    assign w_cin[0] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            if (g > 0) begin : g_chain
                assign w_cin[g] = w_cout[g-1];
            end
            bcd_digit_cell u_cell (
                .clk      (clk),
                .resetn   (resetn),
                .clear    (clear),
                .load     (load),
                .load_val (load_val[4*g +: 4]),
                .step     (w_step),
                .up       (up),
                .cin      (w_cin[g]),
                .digit    (w_count[4*g +: 4]),
                .cout     (w_cout[g]),
                .is_max   (w_max[g]),
                .is_zero  (w_zero[g])
            );
        end
    endgenerate

    // Wrap pulse lands in the same cycle as the rolled-over count
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_step & w_cout[DIGITS-1];
        end
    end

    // Encode each digit, blanking upper digits that are part of a leading-zero run
    always_comb begin
        w_hz       = 1'b1;
        w_seg_next = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_hz = w_hz & w_zero[k];
            if (lz_blank && (k != 0) && w_hz) begin
                w_seg_next[8*k +: 8] = SEG_BLANK;
            end else begin
                w_seg_next[8*k +: 8] = seg_encode(w_count[4*k +: 4]);
            end
        end
    end

    // Segment register; reset shows all zeros regardless of blanking
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_seg <= {DIGITS{SEG_0}};
        end else begin
            r_seg <= w_seg_next;
        end
    end

    assign count_bcd = w_count;
    assign tick      = r_tick;
    assign wrap      = r_wrap;
    assign seg       = r_seg;

endmodule

// File: tb/tb_bcd_counter_display.sv
// tb/tb_bcd_counter_display.sv - randomized self-checking bench for bcd_counter_display
module tb_bcd_counter_display;

    localparam int DIGITS   = 2;
    localparam int TICK_DIV = 4;
    localparam int MAXV     = 99;

    logic        clk = 1'b0;
    logic        resetn;
    logic        en;
    logic        up;
    logic        clear;
    logic        load;
    logic [7:0]  load_val;
    logic        wrap_mode;
    logic        lz_blank;
    logic [7:0]  count_bcd;
    logic        tick;
    logic        wrap;
    logic        at_limit;
    logic [15:0] seg;

    int n_chk  = 0;
    int n_pass = 0;

    bcd_counter_display #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .en        (en),
        .up        (up),
        .clear     (clear),
        .load      (load),
        .load_val  (load_val),
        .wrap_mode (wrap_mode),
        .lz_blank  (lz_blank),
        .count_bcd (count_bcd),
        .tick      (tick),
        .wrap      (wrap),
        .at_limit  (at_limit),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    // Reference model: count kept as a plain integer 0..99
    int          m_presc;
    int          m_count;
    bit          m_tick;
    bit          m_wrap;
    logic [15:0] m_seg;

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic int clamp_val(input logic [7:0] v);
        int hi;
        int lo;
        hi = int'(v[7:4]);
        lo = int'(v[3:0]);
        if (hi > 9) hi = 9;
        if (lo > 9) lo = 9;
        return hi * 10 + lo;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] seg_of(input int v, input bit lz);
        logic [7:0] hi;
        hi = (lz && (v / 10 == 0)) ? 8'hFF : seg_tab[v / 10];
        return {hi, seg_tab[v % 10]};
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_presc <= 0;
            m_count <= 0;
            m_tick  <= 1'b0;
            m_wrap  <= 1'b0;
            m_seg   <= 16'hC0C0;
        end else begin
            m_seg <= seg_of(m_count, lz_blank);
            if (clear) begin
                m_presc <= 0;
                m_tick  <= 1'b0;
                m_count <= 0;
                m_wrap  <= 1'b0;
            end else begin
                if (en) begin
                    m_presc <= (m_presc == TICK_DIV - 1) ? 0 : m_presc + 1;
                    m_tick  <= (m_presc == TICK_DIV - 1);
                end else begin
                    m_tick <= 1'b0;
                end
                if (load) begin
                    m_count <= clamp_val(load_val);
                    m_wrap  <= 1'b0;
                end else if (m_tick) begin
                    if (up && m_count == MAXV) begin
                        m_count <= wrap_mode ? 0 : MAXV;
                        m_wrap  <= wrap_mode;
                    end else if (!up && m_count == 0) begin
                        m_count <= wrap_mode ? MAXV : 0;
                        m_wrap  <= wrap_mode;
                    end else begin
                        m_count <= up ? m_count + 1 : m_count - 1;
                        m_wrap  <= 1'b0;
                    end
                end else begin
                    m_wrap <= 1'b0;
                end
            end
        end
    end

    function automatic logic [26:0] exp_vec();
        bit lim;
        lim = up ? (m_count == MAXV) : (m_count == 0);
        return {to_bcd(m_count), m_tick, m_wrap, lim, m_seg};
    endfunction

    function automatic logic [26:0] act_vec();
        return {count_bcd, tick, wrap, at_limit, seg};
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0; en = 1'b0; up = 1'b0; clear = 1'b0; load = 1'b0;
        load_val = 8'h00; wrap_mode = 1'b0; lz_blank = 1'b1;
        cyc(); cyc();
        n_chk++;
        if ({count_bcd, tick, wrap, seg} !== {8'h00, 1'b0, 1'b0, 16'hC0C0})
            $display("FAIL reset_state act=%h exp=%h", {count_bcd, tick, wrap, seg}, {8'h00, 2'b00, 16'hC0C0});
        else n_pass++;
        resetn = 1'b1;
        lz_blank = 1'b0;
        #1;
        n_chk++;
        if (act_vec() !== exp_vec()) $display("FAIL reset_release act=%h exp=%h", act_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_count_up();
        en = 1'b1; up = 1'b1; wrap_mode = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            n_chk++;
            if (act_vec() !== exp_vec()) $display("FAIL count_up cyc=%0d act=%h exp=%h", i, act_vec(), exp_vec());
            else n_pass++;
        end
        n_chk++;
        if ({count_bcd, seg, tick} !== {8'h02, 16'hC0A4, 1'b1})
            $display("FAIL count_up_end act=%h exp=%h", {count_bcd, seg, tick}, {8'h02, 16'hC0A4, 1'b1});
        else n_pass++;
    endtask

    task automatic test_wrap_up();
        bit saw_wrap;
        saw_wrap = 1'b0;
        up = 1'b1; wrap_mode = 1'b1;
        load = 1'b1; load_val = 8'h98;
        cyc();
        load = 1'b0;
        for (int i = 0; i < 12; i++) begin
            n_chk++;
            if (act_vec() !== exp_vec()) $display("FAIL wrap_up cyc=%0d act=%h exp=%h", i, act_vec(), exp_vec());
            else n_pass++;
            if (wrap && count_bcd == 8'h00) saw_wrap = 1'b1;
            cyc();
        end
        n_chk++;
        if (saw_wrap !== 1'b1) $display("FAIL wrap_up_pulse act=%0d exp=1", saw_wrap);
        else n_pass++;
    endtask

    task automatic test_saturate();
        load = 1'b1; load_val = 8'h00; up = 1'b0; wrap_mode = 1'b0;
        cyc();
        load = 1'b0;
        for (int i = 0; i < 14; i++) begin
            cyc();
            n_chk++;
            if (act_vec() !== exp_vec()) $display("FAIL saturate cyc=%0d act=%h exp=%h", i, act_vec(), exp_vec());
            else n_pass++;
        end
        n_chk++;
        if ({count_bcd, wrap, at_limit} !== {8'h00, 1'b0, 1'b1})
            $display("FAIL saturate_hold act=%h exp=%h", {count_bcd, wrap, at_limit}, {8'h00, 2'b01});
        else n_pass++;
    endtask

    task automatic test_clamp_down();
        load = 1'b1; load_val = 8'hAF; up = 1'b0; wrap_mode = 1'b1;
        cyc();
        load = 1'b0;
        n_chk++;
        if (count_bcd !== 8'h99) $display("FAIL load_clamp act=%h exp=99", count_bcd);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            cyc();
            n_chk++;
            if (act_vec() !== exp_vec()) $display("FAIL down_step cyc=%0d act=%h exp=%h", i, act_vec(), exp_vec());
            else n_pass++;
        end
        load = 1'b1; load_val = 8'h00;
        cyc();
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            n_chk++;
            if (act_vec() !== exp_vec()) $display("FAIL down_wrap cyc=%0d act=%h exp=%h", i, act_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_lz_blank();
        en = 1'b0; lz_blank = 1'b1;
        load = 1'b1; load_val = 8'h05;
        cyc();
        load = 1'b0;
        cyc();
        n_chk++;
        if (seg !== 16'hFF92) $display("FAIL lz_05 act=%h exp=ff92", seg);
        else n_pass++;
        load = 1'b1; load_val = 8'h00;
        cyc();
        load = 1'b0;
        cyc();
        n_chk++;
        if (seg !== 16'hFFC0) $display("FAIL lz_00 act=%h exp=ffc0", seg);
        else n_pass++;
        lz_blank = 1'b0;
        cyc();
        n_chk++;
        if (seg !== 16'hC0C0) $display("FAIL lz_off act=%h exp=c0c0", seg);
        else n_pass++;
    endtask

    task automatic test_clear_priority();
        int wait_n;
        bit found;
        en = 1'b1; up = 1'b1; wrap_mode = 1'b1;
        load = 1'b1; load_val = 8'h42;
        cyc();
        load = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (tick) found = 1'b1;
            else cyc();
        end
        n_chk++;
        if (!found || count_bcd !== 8'h42) $display("FAIL clr_setup act=%h found=%0d exp=42", count_bcd, found);
        else n_pass++;
        clear = 1'b1; load = 1'b1; load_val = 8'($urandom);
        cyc();
        clear = 1'b0; load = 1'b0;
        n_chk++;
        if (act_vec() !== exp_vec() || count_bcd !== 8'h00)
            $display("FAIL clr_load act=%h exp=%h", act_vec(), exp_vec());
        else n_pass++;
        wait_n = 0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc();
            wait_n++;
            if (tick) found = 1'b1;
        end
        n_chk++;
        if (wait_n != TICK_DIV || !found) $display("FAIL clr_next_tick act=%0d exp=%0d", wait_n, TICK_DIV);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        int wait_n;
        bit found;
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 9; i++) cyc();
        #2;
        resetn = 1'b0;
        #1;
        n_chk++;
        if ({count_bcd, tick, wrap, seg} !== {8'h00, 2'b00, 16'hC0C0})
            $display("FAIL mid_reset act=%h exp=%h", {count_bcd, tick, wrap, seg}, {8'h00, 2'b00, 16'hC0C0});
        else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
        wait_n = 0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc();
            wait_n++;
            if (tick) found = 1'b1;
        end
        n_chk++;
        if (wait_n != TICK_DIV || !found) $display("FAIL reset_first_tick act=%0d exp=%0d", wait_n, TICK_DIV);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            en        = ($urandom_range(0, 7) != 0);
            up        = 1'($urandom);
            wrap_mode = 1'($urandom);
            lz_blank  = 1'($urandom);
            clear     = ($urandom_range(0, 31) == 0);
            load      = ($urandom_range(0, 15) == 0);
            load_val  = ($urandom_range(0, 3) == 0) ? 8'h99 : 8'($urandom);
            cyc();
            n_chk++;
            if (act_vec() !== exp_vec()) $display("FAIL random cyc=%0d act=%h exp=%h", i, act_vec(), exp_vec());
            else n_pass++;
        end
        clear = 1'b0; load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap_up();
        test_saturate();
        test_clamp_down();
        test_lz_blank();
        test_clear_priority();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
